maze_path_replayer: RTL and testbench

//  Consumer end of the rat's 2-bit move stream: buffers moves, replays them from (0,0) over the same 16x16 maze memory.

---
 rtl/maze_path_replayer_pkg.sv | 59 +++++
 rtl/maze_path_replayer_if.sv | 13 +
 rtl/maze_path_replayer_move_fifo.sv | 65 ++++++
 rtl/maze_path_replayer.sv | 198 +++++++++++++++++++
 tb/tb_maze_path_replayer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_path_replayer_pkg.sv
// Shared types for the maze path replayer: moves, failure causes, FSM states, FIFO entry
// and the single-step target helper.
package maze_path_replayer_pkg;

  localparam int unsigned MAZE_DIM = 16;
  localparam int unsigned COORD_W  = 4;
  localparam int unsigned MOVE_W   = 2;

  typedef enum logic [MOVE_W-1:0] {
    MV_RIGHT = 2'b00,
    MV_UP    = 2'b01,
    MV_LEFT  = 2'b10,
    MV_DOWN  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_WALL     = 2'b01,
    FC_OOB      = 2'b10,
    FC_OFF_GOAL = 2'b11
  } fail_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LOOK,
    ST_DONE,
    ST_FAIL
  } replay_state_t;

  typedef struct packed {
    logic  last;
    move_t move;
  } mv_entry_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               oob;
  } step_t;

  // Target cell of one move; oob flags a step off the grid edge.
  function automatic step_t step_target(input logic [COORD_W-1:0] cx,
                                        input logic [COORD_W-1:0] cy,
                                        input move_t              mv);
    step_t              s;
    logic [COORD_W-1:0] max_c;
    max_c = COORD_W'(MAZE_DIM - 1);
    s     = '{x: cx, y: cy, oob: 1'b0};
    unique case (mv)
      MV_RIGHT: begin s.oob = (cx == max_c);   s.x = cx + COORD_W'(1); end
      MV_UP:    begin s.oob = (cy == '0);      s.y = cy - COORD_W'(1); end
      MV_LEFT:  begin s.oob = (cx == '0);      s.x = cx - COORD_W'(1); end
      MV_DOWN:  begin s.oob = (cy == max_c);   s.y = cy + COORD_W'(1); end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/maze_path_replayer_if.sv
// Move stream from the maze solver (master) into the replayer (slave).
interface maze_path_replayer_if;
  import maze_path_replayer_pkg::*;

  logic  mv_valid;
  move_t mv_data;
  logic  mv_last;
  logic  mv_ready;

  modport master (output mv_valid, output mv_data, output mv_last, input  mv_ready);
  modport slave  (input  mv_valid, input  mv_data, input  mv_last, output mv_ready);

endinterface

// File: rtl/maze_path_replayer_move_fifo.sv
// DEPTH x {last, move} FIFO with show-ahead read and synchronous flush.
// full_next is the full flag of the following cycle, used to register the upstream ready.
module maze_path_replayer_move_fifo
  import maze_path_replayer_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  mv_entry_t push_data,
  input  logic      pop,
  output mv_entry_t rd_data,
  output logic      empty,
  output logic      full_next
);

  localparam int unsigned CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  mv_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push && (cnt_q != FULL_CNT) && !flush;
    do_pop   = pop && (cnt_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign empty     = (cnt_q == '0);
  assign full_next = (cnt_d == FULL_CNT);

endmodule

// File: rtl/maze_path_replayer.sv
// Replays buffered rat moves from (0,0) against the maze memory, checking bounds and walls,
// and reports done on a clean walk ending at the goal, else fail with a cause code.
module maze_path_replayer
  import maze_path_replayer_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned AW         = 8,
  parameter int unsigned STEP_DELAY = 0,
  parameter int unsigned GOAL_X     = 15,
  parameter int unsigned GOAL_Y     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  maze_path_replayer_if.slave  mv,
  output logic [COORD_W-1:0]   x,
  output logic [COORD_W-1:0]   y,
  input  logic                 dout,
  output logic [COORD_W-1:0]   px,
  output logic [COORD_W-1:0]   py,
  output logic                 step_valid,
  output logic [AW:0]          step_cnt,
  output logic                 done,
  output logic                 fail,
  output logic [1:0]           fail_code
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (STEP_DELAY > 0) ? $clog2(STEP_DELAY + 1) : 1;
  localparam logic [COORD_W-1:0] GX = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY = COORD_W'(GOAL_Y);

  replay_state_t      state_q, state_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, nx_q, nx_d, ny_q, ny_d;
  logic [COORD_W-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
  logic [DW-1:0]      delay_q, delay_d;
  logic [CW-1:0]      step_cnt_q, step_cnt_d;
  logic               last_q, last_d, last_seen_q, last_seen_d;
  logic               step_valid_q, step_valid_d, done_q, done_d, fail_q, fail_d;
  logic               mv_ready_q, mv_ready_d;
  fail_code_t         fail_code_q, fail_code_d;

  logic      push, pop, flush, fifo_empty, fifo_full_next;
  mv_entry_t head;
  step_t     tgt;

  assign push = mv.mv_valid && mv_ready_q;
  assign tgt  = step_target(px_q, py_q, head.move);

  maze_path_replayer_move_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ('{last: mv.mv_last, move: mv.mv_data}),
    .pop       (pop),
    .rd_data   (head),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  // Replay sequencing: RUN pops and addresses the target cell, LOOK checks the wall bit and commits.
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    last_d       = last_q;
    addr_x_d     = addr_x_q;
    addr_y_d     = addr_y_q;
    delay_d      = delay_q;
    step_cnt_d   = step_cnt_q;
    step_valid_d = 1'b0;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_code_d  = fail_code_q;
    last_seen_d  = last_seen_q | (push & mv.mv_last);
    pop          = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d     = ST_RUN;
          px_d        = '0;
          py_d        = '0;
          addr_x_d    = '0;
          addr_y_d    = '0;
          last_d      = 1'b0;
          delay_d     = '0;
          step_cnt_d  = '0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FC_NONE;
          last_seen_d = 1'b0;
          flush       = 1'b1;
        end
      end
      ST_RUN: begin
        if (delay_q != '0) begin
          delay_d = delay_q - DW'(1);
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (tgt.oob) begin
            state_d     = ST_FAIL;
            fail_d      = 1'b1;
            fail_code_d = FC_OOB;
          end else begin
            nx_d     = tgt.x;
            ny_d     = tgt.y;
            last_d   = head.last;
            addr_x_d = tgt.x;
            addr_y_d = tgt.y;
            state_d  = ST_LOOK;
          end
        end
      end
      ST_LOOK: begin
        if (dout) begin
          state_d     = ST_FAIL;
          fail_d      = 1'b1;
          fail_code_d = FC_WALL;
        end else begin
          px_d         = nx_q;
          py_d         = ny_q;
          step_valid_d = 1'b1;
          step_cnt_d   = (step_cnt_q == '1) ? step_cnt_q : step_cnt_q + CW'(1);
          delay_d      = DW'(STEP_DELAY);
          if (!last_q) begin
            state_d = ST_RUN;
          end else if (nx_q == GX && ny_q == GY) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_FAIL;
            fail_d      = 1'b1;
            fail_code_d = FC_OFF_GOAL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full blocks acceptance regardless of a same-cycle pop, since full_next ignores future pops.
  assign mv_ready_d = ((state_d == ST_RUN) || (state_d == ST_LOOK)) && !fifo_full_next && !last_seen_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      last_q       <= 1'b0;
      addr_x_q     <= '0;
      addr_y_q     <= '0;
      delay_q      <= '0;
      step_cnt_q   <= '0;
      step_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
      last_seen_q  <= 1'b0;
      mv_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      last_q       <= last_d;
      addr_x_q     <= addr_x_d;
      addr_y_q     <= addr_y_d;
      delay_q      <= delay_d;
      step_cnt_q   <= step_cnt_d;
      step_valid_q <= step_valid_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
      last_seen_q  <= last_seen_d;
      mv_ready_q   <= mv_ready_d;
    end
  end

  // The address leads by one cycle so the memory answers during LOOK.
  assign x           = addr_x_d;
  assign y           = addr_y_d;
  assign px          = px_q;
  assign py          = py_q;
  assign step_valid  = step_valid_q;
  assign step_cnt    = step_cnt_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign fail_code   = fail_code_q;
  assign mv.mv_ready = mv_ready_q;

endmodule

// File: tb/tb_maze_path_replayer.sv
// Directed bench: a default replayer (DEPTH 256, no pacing) and a small one (DEPTH 4,
// STEP_DELAY 3, goal (3,3)), each with its own maze memory model.
module tb_maze_path_replayer;
  import maze_path_replayer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  always #5 clk = ~clk;

  maze_path_replayer_if mif_a ();
  maze_path_replayer_if mif_b ();

  logic [3:0] x_a, y_a, px_a, py_a, x_b, y_b, px_b, py_b;
  logic       dout_a, dout_b, sv_a, sv_b, done_a, done_b, fail_a, fail_b;
  logic [8:0] cnt_a;
  logic [2:0] cnt_b;
  logic [1:0] fc_a, fc_b;

  maze_path_replayer u_a (
    .clk(clk), .rst(rst), .start(start_a), .mv(mif_a.slave), .x(x_a), .y(y_a), .dout(dout_a),
    .px(px_a), .py(py_a), .step_valid(sv_a), .step_cnt(cnt_a), .done(done_a), .fail(fail_a),
    .fail_code(fc_a)
  );

  maze_path_replayer #(.DEPTH(4), .AW(2), .STEP_DELAY(3), .GOAL_X(3), .GOAL_Y(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mv(mif_b.slave), .x(x_b), .y(y_b), .dout(dout_b),
    .px(px_b), .py(py_b), .step_valid(sv_b), .step_cnt(cnt_b), .done(done_b), .fail(fail_b),
    .fail_code(fc_b)
  );

  logic wall_a [256];
  logic wall_b [256];
  always @(posedge clk) begin
    dout_a <= wall_a[{y_a, x_a}];
    dout_b <= wall_b[{y_b, x_b}];
  end

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int pulses_a = 0, addr_off_a = 0, pulses_b = 0, last_pulse_b = -1;
  int base_pulses_a, base_addr_a, stall_b;
  int gaps_b [$];
  logic [7:0] pos_b [$];
  logic [1:0] path_a [$];
  logic [1:0] path_b [$];
  logic [7:0] exp_pos_b [10] = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h32, 8'h33, 8'h23, 8'h22, 8'h32, 8'h33};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sv_a) pulses_a++;
    if (x_a != 4'd0 || y_a != 4'd0) addr_off_a++;
    if (sv_b) begin
      pulses_b++;
      if (last_pulse_b >= 0) gaps_b.push_back(cyc - last_pulse_b);
      last_pulse_b = cyc;
      pos_b.push_back({px_b, py_b});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_a_pulse();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a       = 1'b0;
    base_pulses_a = pulses_a;
    base_addr_a   = addr_off_a;
  endtask

  task automatic feed_a();
    bit ok;
    for (int i = 0; i < path_a.size(); i++) begin
      mif_a.mv_valid = 1'b1;
      mif_a.mv_data  = move_t'(path_a[i]);
      mif_a.mv_last  = (i == path_a.size() - 1);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (mif_a.mv_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("a_accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
    end
    mif_a.mv_valid = 1'b0;
    mif_a.mv_last  = 1'b0;
  endtask

  task automatic feed_b();
    bit ok;
    for (int i = 0; i < path_b.size(); i++) begin
      mif_b.mv_valid = 1'b1;
      mif_b.mv_data  = move_t'(path_b[i]);
      mif_b.mv_last  = (i == path_b.size() - 1);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (mif_b.mv_ready) begin ok = 1'b1; break; end
        stall_b++;
      end
      if (!ok) chk("b_accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
    end
    mif_b.mv_valid = 1'b0;
    mif_b.mv_last  = 1'b0;
  endtask

  task automatic wait_end_a();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_a || fail_a) break;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos"}, 32'({x_a, y_a, px_a, py_a}), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt_a), 32'd0);
    chk({tag, "_flags"}, 32'({mif_a.mv_ready, sv_a, done_a, fail_a, fc_a}), 32'd0);
  endtask

  task automatic open_path_a();
    path_a.delete();
    repeat (15) path_a.push_back(2'd0);
    repeat (15) path_a.push_back(2'd3);
  endtask

  task automatic run_open_a(input string tag);
    open_path_a();
    start_a_pulse();
    feed_a();
    wait_end_a();
    chk({tag, "_done"}, 32'({done_a, fail_a, fc_a}), 32'h8);
    chk({tag, "_pos"}, 32'({px_a, py_a}), 32'hff);
    chk({tag, "_cnt"}, 32'(cnt_a), 32'd30);
    chk({tag, "_pulses"}, 32'(pulses_a - base_pulses_a), 32'd30);
  endtask

  initial begin
    rst     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mif_a.mv_valid = 1'b0; mif_a.mv_data = MV_RIGHT; mif_a.mv_last = 1'b0;
    mif_b.mv_valid = 1'b0; mif_b.mv_data = MV_RIGHT; mif_b.mv_last = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wall_a[i] = 1'b0;
      wall_b[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(mif_a.mv_ready), 32'd0);

    // Open maze, 15 right then 15 down, ends on the goal.
    run_open_a("open");

    // Wall directly right of the origin.
    wall_a[8'h01] = 1'b1;
    path_a.delete();
    path_a.push_back(2'd0);
    start_a_pulse();
    feed_a();
    wait_end_a();
    chk("wall_code", 32'({done_a, fail_a, fc_a}), 32'h5);
    chk("wall_pos", 32'({px_a, py_a}), 32'h00);
    chk("wall_cnt", 32'(cnt_a), 32'd0);
    wall_a[8'h01] = 1'b0;

    // Left from the origin leaves the grid without touching memory.
    path_a.delete();
    path_a.push_back(2'd2);
    start_a_pulse();
    feed_a();
    wait_end_a();
    chk("oob_code", 32'({done_a, fail_a, fc_a}), 32'h6);
    chk("oob_pos", 32'({px_a, py_a, cnt_a}), 32'd0);
    chk("oob_addr", 32'(addr_off_a - base_addr_a), 32'd0);
    chk("oob_pulses", 32'(pulses_a - base_pulses_a), 32'd0);

    // Single step ends off the goal.
    path_a.delete();
    path_a.push_back(2'd0);
    start_a_pulse();
    feed_a();
    wait_end_a();
    chk("offgoal_code", 32'({done_a, fail_a, fc_a}), 32'h7);
    chk("offgoal_pos", 32'({px_a, py_a}), 32'h10);
    chk("offgoal_cnt", 32'(cnt_a), 32'd1);
    chk("offgoal_pulses", 32'(pulses_a - base_pulses_a), 32'd1);

    // Small FIFO with pacing: backpressure, order, 5-cycle pulse period, counter saturates at 7.
    path_b = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    stall_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    feed_b();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_b || fail_b) break;
    end
    @(negedge clk);
    chk("small_done", 32'({done_b, fail_b, fc_b}), 32'h8);
    chk("small_pos", 32'({px_b, py_b}), 32'h33);
    chk("small_cnt_sat", 32'(cnt_b), 32'd7);
    chk("small_pulses", 32'(pulses_b), 32'd10);
    chk("small_stalled", 32'(stall_b > 0), 32'd1);
    chk("small_ngaps", 32'(gaps_b.size()), 32'd9);
    foreach (gaps_b[i]) chk("small_gap", 32'(gaps_b[i]), 32'd5);
    for (int i = 0; i < 10 && i < pos_b.size(); i++) chk("small_order", 32'(pos_b[i]), 32'(exp_pos_b[i]));

    // Reset during the LOOK cycle of step 5, then a fresh session.
    path_a.delete();
    repeat (6) path_a.push_back(2'd0);
    start_a_pulse();
    feed_a();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sv_a && cnt_a == 9'd4) break;
    end
    chk("pre_rst_px", 32'({px_a, cnt_a}), 32'({4'd4, 9'd4}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b1;
    @(negedge clk);
    run_open_a("again");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 50000", cyc);
    $fatal(1);
  end

endmodule
